i2c_burst_master: RTL and testbench

I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_clk_gen.sv | 52 +++++
 rtl/i2c_burst_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_burst_master.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst master: FSM encoding, SCL quarter phases
// and the R/W bit values that follow the 7-bit address.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic [7:0] addr_byte(input logic [6:0] a, input logic rw);
        return {a, rw};
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator for SCL; tick fires on the last clk of each
// quarter and phase names the quarter that is ending.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       restart,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick    = 1'b0;
        if (restart) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (!hold) begin
            if (cnt_q == CNT_LAST) begin
                tick    = 1'b1;
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i2c_burst_master.sv
// I2C master moving up to MAX_BYTES bytes per transaction to/from one 7-bit slave.
// Each bit: SDA set after Q0, SCL high after Q1, SDA sampled after Q2, SCL low after Q3.
module i2c_burst_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 5,
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic             enable,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    inout  wire              i2c_sda,
    output logic             i2c_scl
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t           state_q, state_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nack_q, nack_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             rw_q, rw_d;
    logic             loaded_q, loaded_d;
    logic             ack_q, ack_d;

    logic             tick, hold, accept, sda_in, last_byte, drive_low;
    logic [1:0]       phase;
    logic [LEN_W-1:0] len_clamped;

    assign sda_in      = i2c_sda;
    assign accept      = enable && !busy_q;
    assign hold        = (state_q == ST_WDATA) && !loaded_q;
    assign last_byte   = (byte_cnt_q <= ONE);
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .restart (accept),
        .tick    (tick),
        .phase   (phase)
    );

    always_comb begin
        case (state_q)
            ST_ADDR, ST_WDATA: drive_low = ~shreg_q[7];
            ST_RACK:           drive_low = ~last_byte;
            default:           drive_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rw_d       = rw_q;
        loaded_d   = loaded_q;
        ack_d      = ack_q;

        unique case (state_q)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                if (tick) begin
                    case (phase)
                        Q0:      sda_oe_d = 1'b1;
                        Q1:      scl_d    = 1'b0;
                        Q3: begin
                            state_d   = ST_ADDR;
                            bit_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STOP: begin
                // Extra cycle after done lets busy fall one cycle before IDLE.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    case (phase)
                        Q0: sda_oe_d = 1'b1;
                        Q1: scl_d    = 1'b1;
                        Q2: sda_oe_d = 1'b0;
                        default: begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                // Write byte fetch: wr_ready is raised, wr_data captured while it is high.
                if (hold) begin
                    if (wr_ready_q) begin
                        shreg_d  = wr_data;
                        loaded_d = 1'b1;
                    end else if (wr_valid) begin
                        wr_ready_d = 1'b1;
                    end
                end else if (tick) begin
                    case (phase)
                        Q0: sda_oe_d = drive_low;
                        Q1: scl_d    = 1'b1;
                        Q2: begin
                            ack_d = sda_in;
                            if (state_q == ST_RDATA) begin
                                shreg_d = {shreg_q[6:0], sda_in};
                                if (bit_cnt_q == 3'd7) begin
                                    rd_data_d  = {shreg_q[6:0], sda_in};
                                    rd_valid_d = 1'b1;
                                end
                            end
                        end
                        default: begin
                            scl_d = 1'b0;
                            case (state_q)
                                ST_ADDR, ST_WDATA, ST_RDATA: begin
                                    if (state_q != ST_RDATA) shreg_d = {shreg_q[6:0], 1'b0};
                                    bit_cnt_d = bit_cnt_q + 3'd1;
                                    if (bit_cnt_q == 3'd7) begin
                                        bit_cnt_d = '0;
                                        state_d   = (state_q == ST_ADDR)  ? ST_ADDR_ACK :
                                                    (state_q == ST_WDATA) ? ST_WACK : ST_RACK;
                                    end
                                end
                                ST_ADDR_ACK: begin
                                    if (ack_q) begin
                                        nack_d  = 1'b1;
                                        state_d = ST_STOP;
                                    end else if (byte_cnt_q == '0) begin
                                        state_d = ST_STOP;
                                    end else if (rw_q == RW_READ) begin
                                        state_d = ST_RDATA;
                                    end else begin
                                        state_d  = ST_WDATA;
                                        loaded_d = 1'b0;
                                    end
                                end
                                ST_WACK, ST_RACK: begin
                                    if (state_q == ST_WACK && ack_q) begin
                                        nack_d  = 1'b1;
                                        state_d = ST_STOP;
                                    end else begin
                                        byte_cnt_d = (byte_cnt_q != '0) ? byte_cnt_q - ONE : '0;
                                        if (last_byte) begin
                                            state_d = ST_STOP;
                                        end else if (state_q == ST_WACK) begin
                                            state_d  = ST_WDATA;
                                            loaded_d = 1'b0;
                                        end else begin
                                            state_d = ST_RDATA;
                                        end
                                    end
                                end
                                default: state_d = ST_STOP;
                            endcase
                        end
                    endcase
                end
            end
        endcase

        if (accept) begin
            state_d    = ST_START;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            nack_d     = 1'b0;
            scl_d      = 1'b1;
            sda_oe_d   = 1'b0;
            shreg_d    = addr_byte(addr, rw);
            rw_d       = rw;
            byte_cnt_d = len_clamped;
            bit_cnt_d  = '0;
            loaded_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rw_q       <= RW_WRITE;
            loaded_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rw_q       <= rw_d;
            loaded_q   <= loaded_d;
            ack_q      <= ack_d;
        end
    end

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign i2c_scl  = scl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack     = nack_q;
    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_i2c_burst_master.sv
// Directed bench for i2c_burst_master with a behavioural slave at address 7'h14.
module tb_i2c_burst_master;

    localparam logic [6:0] SLV_ADDR = 7'h14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [4:0] len = 5'd0;
    logic       enable = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy, done, nack;
    logic       scl_w;
    wire        sda_w;

    logic       slv_pull = 1'b0;
    assign sda_w = slv_pull ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_burst_master #(.CLK_DIV(5), .MAX_BYTES(16), .LEN_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .rw       (rw),
        .len      (len),
        .enable   (enable),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .nack     (nack),
        .i2c_sda  (sda_w),
        .i2c_scl  (scl_w)
    );

    always #5 clk = ~clk;

    // Behavioural slave
    int         bitn = 0;
    int         stage = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] rd_sh = 8'h00;
    logic [7:0] addr_seen = 8'h00;
    bit         addressed = 1'b0;
    bit         is_read = 1'b0;
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    logic       mack[$];
    int         start_cnt = 0;
    int         stop_cnt = 0;

    always @(negedge sda_w) begin
        if (scl_w === 1'b1) begin
            start_cnt++;
            bitn = 0;
            stage = 0;
            addressed = 1'b0;
            slv_pull = 1'b0;
        end
    end

    always @(posedge sda_w) begin
        if (scl_w === 1'b1) stop_cnt++;
    end

    always @(posedge scl_w) begin
        bitn++;
        if (bitn <= 8) sh = {sh[6:0], sda_w};
        else if (stage == 1 && addressed && is_read) mack.push_back(sda_w);
    end

    always @(negedge scl_w) begin
        if (bitn == 8) begin
            if (stage == 0) begin
                addr_seen = sh;
                addressed = (sh[7:1] == SLV_ADDR);
                is_read   = sh[0];
                slv_pull  = addressed;
            end else if (addressed && !is_read) begin
                wq.push_back(sh);
                slv_pull = 1'b1;
            end else begin
                slv_pull = 1'b0;
            end
        end else if (bitn == 9) begin
            bitn = 0;
            slv_pull = 1'b0;
            if (addressed && is_read && (stage == 0 || mack[$] == 1'b0) && rq.size() > 0) begin
                rd_sh = rq.pop_front();
                slv_pull = !rd_sh[7];
            end
            stage = 1;
        end else if (stage == 1 && addressed && is_read && bitn >= 1) begin
            slv_pull = !rd_sh[3'(7 - bitn)];
        end
    end

    // Bench bookkeeping
    int         checks = 0;
    int         errors = 0;
    logic [7:0] wsrc[0:31];
    int         wr_cnt = 0;
    int         scl_rises = 0;
    logic [7:0] rd_got[$];
    bit         got_done = 1'b0;
    logic       busy_at_done = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cnt = 0;
        scl_rises = 0;
        rd_got.delete();
        wq.delete();
        mack.delete();
    endtask

    task automatic start_txn(input logic [6:0] a, input logic r, input logic [4:0] l);
        @(negedge clk);
        addr = a;
        rw = r;
        len = l;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_txn(input int budget);
        bit   pend;
        logic prev;
        pend = 1'b0;
        got_done = 1'b0;
        busy_at_done = 1'b1;
        prev = scl_w;
        wr_data = wsrc[wr_cnt];
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pend) begin
                wr_data = wsrc[wr_cnt];
                pend = 1'b0;
            end
            if (wr_ready) begin
                wr_cnt++;
                pend = 1'b1;
            end
            if (rd_valid) rd_got.push_back(rd_data);
            if (scl_w && !prev) scl_rises++;
            prev = scl_w;
            if (done) begin
                got_done = 1'b1;
                busy_at_done = busy;
                break;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("busy_low_with_done", 32'(busy_at_done), 32'd0);
    endtask

    initial begin
        int   n;
        int   lowcnt;
        int   rdy;
        int   dn;
        bit   found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl_w), 32'd1);
        check("rst_sda", 32'(sda_w), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);

        // Write 3 bytes, enable presented on the first edge after reset release
        clear_logs();
        wsrc[0] = 8'hAA; wsrc[1] = 8'h55; wsrc[2] = 8'h0F;
        n = start_cnt;
        @(negedge clk);
        rst = 1'b0;
        addr = 7'h14; rw = 1'b0; len = 5'd3;
        wr_data = wsrc[0]; wr_valid = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        check("w3_busy_first_edge", 32'(busy), 32'd1);
        run_txn(2000);
        check("w3_wr_ready_cnt", 32'(wr_cnt), 32'd3);
        check("w3_addr_byte", 32'(addr_seen), 32'h28);
        check("w3_bytes", 32'(wq.size()), 32'd3);
        check("w3_b0", 32'(wq[0]), 32'hAA);
        check("w3_b1", 32'(wq[1]), 32'h55);
        check("w3_b2", 32'(wq[2]), 32'h0F);
        check("w3_nack", 32'(nack), 32'd0);
        check("w3_scl_pulses", 32'(scl_rises), 32'd37);
        check("w3_start_seen", 32'(start_cnt - n), 32'd1);
        @(negedge clk);
        check("w3_sda_idle", 32'(sda_w), 32'd1);
        check("w3_scl_idle", 32'(scl_w), 32'd1);

        // Read 2 bytes
        clear_logs();
        wr_valid = 1'b0;
        rq.delete();
        rq.push_back(8'hC3);
        rq.push_back(8'h3C);
        n = stop_cnt;
        start_txn(7'h14, 1'b1, 5'd2);
        run_txn(2000);
        check("r2_rd_cnt", 32'(rd_got.size()), 32'd2);
        check("r2_d0", 32'(rd_got[0]), 32'hC3);
        check("r2_d1", 32'(rd_got[1]), 32'h3C);
        check("r2_mack_cnt", 32'(mack.size()), 32'd2);
        check("r2_ack_byte1", 32'(mack[0]), 32'd0);
        check("r2_nack_byte2", 32'(mack[1]), 32'd1);
        check("r2_stop_seen", 32'(stop_cnt - n), 32'd1);
        check("r2_scl_pulses", 32'(scl_rises), 32'd28);
        check("r2_nack", 32'(nack), 32'd0);

        // Address NACK
        clear_logs();
        wr_valid = 1'b1;
        start_txn(7'h22, 1'b0, 5'd2);
        run_txn(2000);
        check("an_nack", 32'(nack), 32'd1);
        check("an_wr_ready_cnt", 32'(wr_cnt), 32'd0);
        check("an_scl_pulses", 32'(scl_rises), 32'd10);
        @(negedge clk);
        check("an_nack_sticky", 32'(nack), 32'd1);

        // Underrun before byte 2
        clear_logs();
        wsrc[0] = 8'hA1; wsrc[1] = 8'hB2;
        wr_data = wsrc[0];
        wr_valid = 1'b1;
        start_txn(7'h14, 1'b0, 5'd2);
        check("ur_nack_cleared", 32'(nack), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (wr_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("ur_first_ready", 32'(found), 32'd1);
        wr_cnt = 1;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data = wsrc[1];
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (wq.size() == 1 && bitn == 0 && scl_w == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("ur_reached_byte2", 32'(found), 32'd1);
        lowcnt = 0;
        rdy = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!scl_w) lowcnt++;
            if (wr_ready) rdy++;
        end
        check("ur_scl_held_low", 32'(lowcnt), 32'd50);
        check("ur_no_ready_while_stalled", 32'(rdy), 32'd0);
        wr_valid = 1'b1;
        run_txn(2000);
        check("ur_wr_ready_cnt", 32'(wr_cnt), 32'd2);
        check("ur_bytes", 32'(wq.size()), 32'd2);
        check("ur_b0", 32'(wq[0]), 32'hA1);
        check("ur_b1", 32'(wq[1]), 32'hB2);

        // Address probe
        clear_logs();
        start_txn(7'h14, 1'b0, 5'd0);
        run_txn(2000);
        check("pr_wr_ready_cnt", 32'(wr_cnt), 32'd0);
        check("pr_bytes", 32'(wq.size()), 32'd0);
        check("pr_scl_pulses", 32'(scl_rises), 32'd10);
        check("pr_nack", 32'(nack), 32'd0);

        // len beyond MAX_BYTES
        clear_logs();
        for (int i = 0; i < 32; i++) wsrc[i] = 8'(i * 7 + 1);
        start_txn(7'h14, 1'b0, 5'd20);
        run_txn(5000);
        check("cl_wr_ready_cnt", 32'(wr_cnt), 32'd16);
        check("cl_bytes", 32'(wq.size()), 32'd16);
        check("cl_first", 32'(wq[0]), 32'h01);
        check("cl_last", 32'(wq[15]), 32'h6A);
        check("cl_scl_pulses", 32'(scl_rises), 32'd154);

        // Reset during the 4th data bit
        clear_logs();
        wsrc[0] = 8'h5A; wsrc[1] = 8'hC6;
        wr_data = wsrc[0];
        start_txn(7'h14, 1'b0, 5'd2);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (stage == 1 && bitn == 3 && scl_w == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_reached_bit4", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_scl_released", 32'(scl_w), 32'd1);
        check("mr_sda_released", 32'(sda_w), 32'd1);
        check("mr_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("mr_no_done", 32'(dn), 32'd0);
        check("mr_idle_busy", 32'(busy), 32'd0);
        clear_logs();
        wsrc[0] = 8'h3E;
        start_txn(7'h14, 1'b0, 5'd1);
        run_txn(2000);
        check("mr_next_wr_cnt", 32'(wr_cnt), 32'd1);
        check("mr_next_byte", 32'(wq[0]), 32'h3E);
        check("mr_next_nack", 32'(nack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
